// File: rtl/input_unit.sv
// Input-port flit FIFO plus wormhole packet tracker feeding route_compute and the switch allocator.
// Optional drop counter port enabled by defining INPUT_UNIT_DROP_CNT_EN.
module input_unit #(
  parameter int IP_SIZE   = 8,
  parameter int OP_SIZE   = 3,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IP_SIZE-1:0]             in_flit,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [IP_SIZE-1:0]             rc_flit,
  input  logic [OP_SIZE-1:0]             rc_op_port,
  output logic                           sa_req,
  output logic [OP_SIZE-1:0]             sa_port,
  input  logic                           sa_grant,
  output logic [IP_SIZE-1:0]             out_flit,
  output logic                           out_valid,
  output logic [$clog2(BUF_DEPTH):0]     fill
`ifdef INPUT_UNIT_DROP_CNT_EN
  ,
  output logic [7:0]                     drop_cnt
`endif
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int FILL_W = PTR_W + 1;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_INV  = 2'b11;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic                       head_pending_q, head_pending_d;
  logic [OP_SIZE-1:0]         route_q, route_d;
  logic [IP_SIZE-1:0]         mem_q [BUF_DEPTH];
  logic [IP_SIZE-1:0]         mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [IP_SIZE-1:0]         out_flit_q, out_flit_d;
  logic                       out_valid_q, out_valid_d;
  logic [7:0]                 drop_cnt_q, drop_cnt_d;

  logic                       empty_s, full_s, push_s, pop_s, req_s, gpop_s, drop_s;
  logic [IP_SIZE-1:0]         front_s;
  logic [1:0]                 ftype_s;

  always_comb begin
    empty_s = (fill_q == {FILL_W{1'b0}});
    full_s  = (fill_q == FILL_W'(BUF_DEPTH));
    front_s = mem_q[rd_ptr_q];
    ftype_s = front_s[1:0];
    push_s  = in_valid && !full_s;
  end

  // Packet FSM: route capture, request generation, discard and pop decisions.
  always_comb begin
    state_d        = state_q;
    head_pending_d = head_pending_q;
    route_d        = route_q;
    req_s          = 1'b0;
    pop_s          = 1'b0;
    gpop_s         = 1'b0;
    drop_s         = 1'b0;
    case (state_q)
      IDLE: begin
        if (empty_s) begin
          state_d = IDLE;
        end else if (ftype_s == T_HEAD) begin
          route_d        = rc_op_port;
          state_d        = ACTIVE;
          head_pending_d = 1'b1;
        end else begin
          pop_s  = 1'b1;
          drop_s = 1'b1;
        end
      end
      ACTIVE: begin
        if (empty_s) begin
          state_d = ACTIVE;
        end else begin
          case (ftype_s)
            T_HEAD: begin
              if (head_pending_q) begin
                req_s = 1'b1;
              end else begin
                // A second head without a tail: abandon the packet, re-route next cycle.
                state_d = IDLE;
                drop_s  = 1'b1;
              end
            end
            T_INV: begin
              pop_s  = 1'b1;
              drop_s = 1'b1;
            end
            default: req_s = 1'b1;
          endcase
        end
        if (req_s && sa_grant) begin
          pop_s  = 1'b1;
          gpop_s = 1'b1;
          if (ftype_s == T_TAIL) begin
            state_d        = IDLE;
            head_pending_d = 1'b0;
          end else if (ftype_s == T_HEAD) begin
            head_pending_d = 1'b0;
          end else begin
            head_pending_d = head_pending_q;
          end
        end else begin
          gpop_s = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage, pointers and occupancy; a full buffer never accepts, even while popping.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_flit;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Crossbar output register and saturating discard counter.
  always_comb begin
    out_valid_d = gpop_s;
    if (gpop_s) begin
      out_flit_d = front_s;
    end else begin
      out_flit_d = out_flit_q;
    end
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      head_pending_q <= 1'b0;
      route_q        <= {OP_SIZE{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= {IP_SIZE{1'b0}};
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      fill_q         <= {FILL_W{1'b0}};
      out_flit_q     <= {IP_SIZE{1'b0}};
      out_valid_q    <= 1'b0;
      drop_cnt_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      head_pending_q <= head_pending_d;
      route_q        <= route_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fill_q         <= fill_d;
      out_flit_q     <= out_flit_d;
      out_valid_q    <= out_valid_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign in_ready  = !full_s;
  assign rc_flit   = empty_s ? {IP_SIZE{1'b0}} : front_s;
  assign sa_req    = req_s;
  assign sa_port   = route_q;
  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;
  assign fill      = fill_q;
`ifdef INPUT_UNIT_DROP_CNT_EN
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_drop_s;
  assign unused_drop_s = ^drop_cnt_q;
`endif

endmodule

// File: tb/tb_input_unit.sv
// Directed, table-driven bench for input_unit: packet flow, full buffer, orphans, truncation, stall, reset.
module tb_input_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_flit = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rc_flit;
  logic [2:0] rc_op_port = 3'd0;
  logic       sa_req;
  logic [2:0] sa_port;
  logic       sa_grant = 1'b0;
  logic [7:0] out_flit;
  logic       out_valid;
  logic [2:0] fill;
`ifdef INPUT_UNIT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  input_unit dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .rc_flit(rc_flit), .rc_op_port(rc_op_port), .sa_req(sa_req), .sa_port(sa_port),
    .sa_grant(sa_grant), .out_flit(out_flit), .out_valid(out_valid), .fill(fill)
`ifdef INPUT_UNIT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] flit; logic v; logic [2:0] op; logic g;
    int fill; logic rdy; logic req; logic [2:0] port; logic ov; logic [7:0] of;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge and settle before checking.
  task automatic step(input logic [7:0] f, input logic v, input logic [2:0] op, input logic g);
    @(negedge clk);
    in_flit = f; in_valid = v; rc_op_port = op; sa_grant = g;
    #1;
  endtask

  task automatic chk_drop(input string nm, input int exp);
`ifdef INPUT_UNIT_DROP_CNT_EN
    chk(nm, drop_cnt, exp);
`endif
  endtask

  initial begin
    //            flit   v     op    g     fill rdy   req   port  ov    of
    vt[0]  = '{8'h48, 1'b1, 3'd1, 1'b1, 0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[1]  = '{8'h49, 1'b1, 3'd1, 1'b1, 1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[2]  = '{8'h4A, 1'b1, 3'd1, 1'b1, 2, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00};
    vt[3]  = '{8'h00, 1'b0, 3'd1, 1'b1, 2, 1'b1, 1'b1, 3'd1, 1'b1, 8'h48};
    vt[4]  = '{8'h00, 1'b0, 3'd1, 1'b1, 1, 1'b1, 1'b1, 3'd1, 1'b1, 8'h49};
    vt[5]  = '{8'h00, 1'b0, 3'd1, 1'b1, 0, 1'b1, 1'b0, 3'd1, 1'b1, 8'h4A};
    vt[6]  = '{8'h00, 1'b0, 3'd1, 1'b0, 0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h4A};
    vt[7]  = '{8'h80, 1'b1, 3'd2, 1'b0, 0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h4A};
    vt[8]  = '{8'h81, 1'b1, 3'd2, 1'b0, 1, 1'b1, 1'b0, 3'd1, 1'b0, 8'h4A};
    vt[9]  = '{8'h85, 1'b1, 3'd2, 1'b0, 2, 1'b1, 1'b1, 3'd2, 1'b0, 8'h4A};
    vt[10] = '{8'h89, 1'b1, 3'd2, 1'b0, 3, 1'b1, 1'b1, 3'd2, 1'b0, 8'h4A};
    vt[11] = '{8'h8D, 1'b1, 3'd2, 1'b0, 4, 1'b0, 1'b1, 3'd2, 1'b0, 8'h4A};
    vt[12] = '{8'h8D, 1'b1, 3'd2, 1'b1, 4, 1'b0, 1'b1, 3'd2, 1'b0, 8'h4A};
    vt[13] = '{8'h00, 1'b0, 3'd2, 1'b0, 3, 1'b1, 1'b1, 3'd2, 1'b1, 8'h80};
    vt[14] = '{8'h8E, 1'b1, 3'd2, 1'b1, 3, 1'b1, 1'b1, 3'd2, 1'b0, 8'h80};
    vt[15] = '{8'h00, 1'b0, 3'd2, 1'b1, 3, 1'b1, 1'b1, 3'd2, 1'b1, 8'h81};
    vt[16] = '{8'h00, 1'b0, 3'd2, 1'b1, 2, 1'b1, 1'b1, 3'd2, 1'b1, 8'h85};
    vt[17] = '{8'h00, 1'b0, 3'd2, 1'b1, 1, 1'b1, 1'b1, 3'd2, 1'b1, 8'h89};
    vt[18] = '{8'h00, 1'b0, 3'd2, 1'b1, 0, 1'b1, 1'b0, 3'd2, 1'b1, 8'h8E};
    vt[19] = '{8'h00, 1'b0, 3'd2, 1'b0, 0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h8E};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Packet flow and full-buffer behaviour.
    for (int i = 0; i < 20; i++) begin
      step(vt[i].flit, vt[i].v, vt[i].op, vt[i].g);
      chk($sformatf("vec%0d.fill", i), fill, vt[i].fill);
      chk($sformatf("vec%0d.in_ready", i), in_ready, vt[i].rdy);
      chk($sformatf("vec%0d.sa_req", i), sa_req, vt[i].req);
      chk($sformatf("vec%0d.sa_port", i), sa_port, vt[i].port);
      chk($sformatf("vec%0d.out_valid", i), out_valid, vt[i].ov);
      chk($sformatf("vec%0d.out_flit", i), out_flit, vt[i].of);
    end
    chk_drop("drop_after_table", 0);

    // Orphan BODY in IDLE.
    step(8'h05, 1'b1, 3'd0, 1'b0);
    step(8'h00, 1'b0, 3'd0, 1'b1);
    chk("orphan.fill", fill, 1);
    chk("orphan.rc_flit", rc_flit, 8'h05);
    chk("orphan.sa_req", sa_req, 0);
    step(8'h00, 1'b0, 3'd0, 1'b0);
    chk("orphan.popped", fill, 0);
    chk("orphan.out_valid", out_valid, 0);
    chk_drop("orphan.drop", 1);

    // Truncated packet: HEAD, BODY, HEAD, TAIL.
    step(8'h20, 1'b1, 3'd3, 1'b1);
    step(8'h21, 1'b1, 3'd3, 1'b1);
    step(8'h40, 1'b1, 3'd3, 1'b1);
    chk("trunc.req1", sa_req, 1);
    chk("trunc.port1", sa_port, 3);
    step(8'h42, 1'b1, 3'd3, 1'b1);
    chk("trunc.out_head", out_flit, 8'h20);
    step(8'h00, 1'b0, 3'd4, 1'b1);
    chk("trunc.out_body", out_flit, 8'h21);
    chk("trunc.out_body_v", out_valid, 1);
    chk("trunc.newhead_noreq", sa_req, 0);
    step(8'h00, 1'b0, 3'd4, 1'b1);
    chk("trunc.idle_noreq", sa_req, 0);
    chk("trunc.idle_ov", out_valid, 0);
    chk("trunc.fill", fill, 2);
    chk_drop("trunc.drop", 2);
    step(8'h00, 1'b0, 3'd4, 1'b1);
    chk("trunc.req2", sa_req, 1);
    chk("trunc.port2", sa_port, 4);
    step(8'h00, 1'b0, 3'd4, 1'b1);
    chk("trunc.out_head2", out_flit, 8'h40);
    step(8'h00, 1'b0, 3'd4, 1'b0);
    chk("trunc.out_tail", out_flit, 8'h42);
    chk("trunc.out_tail_v", out_valid, 1);
    chk("trunc.end_req", sa_req, 0);

    // Wormhole stall: buffer empties mid-packet.
    step(8'h60, 1'b1, 3'd3, 1'b1);
    step(8'h61, 1'b1, 3'd3, 1'b1);
    step(8'h00, 1'b0, 3'd0, 1'b1);
    chk("stall.req_head", sa_req, 1);
    step(8'h00, 1'b0, 3'd0, 1'b1);
    chk("stall.out_head", out_flit, 8'h60);
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b0, 3'd0, 1'b1);
      chk($sformatf("stall%0d.req", i), sa_req, 0);
      chk($sformatf("stall%0d.port", i), sa_port, 3);
      chk($sformatf("stall%0d.fill", i), fill, 0);
    end
    step(8'h62, 1'b1, 3'd0, 1'b1);
    chk("stall.last_req", sa_req, 0);
    step(8'h00, 1'b0, 3'd0, 1'b1);
    chk("stall.tail_req", sa_req, 1);
    chk("stall.tail_port", sa_port, 3);
    step(8'h00, 1'b0, 3'd0, 1'b0);
    chk("stall.out_tail", out_flit, 8'h62);
    chk("stall.out_tail_v", out_valid, 1);
    chk("stall.idle_req", sa_req, 0);

    // Asynchronous reset mid-packet with three flits buffered.
    step(8'h48, 1'b1, 3'd2, 1'b0);
    step(8'h49, 1'b1, 3'd2, 1'b0);
    step(8'h4A, 1'b1, 3'd2, 1'b0);
    chk("prerst.req", sa_req, 1);
    step(8'h00, 1'b0, 3'd2, 1'b0);
    chk("prerst.fill", fill, 3);
    #1 rst = 1'b1;
    #1;
    chk("rst.fill", fill, 0);
    chk("rst.sa_req", sa_req, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.sa_port", sa_port, 0);
    chk("rst.out_flit", out_flit, 0);
    chk_drop("rst.drop", 0);
    @(negedge clk);
    rst = 1'b0;
    step(8'h10, 1'b1, 3'd1, 1'b1);
    chk("postrst.fill", fill, 0);
    step(8'h12, 1'b1, 3'd1, 1'b1);
    step(8'h00, 1'b0, 3'd1, 1'b1);
    chk("postrst.req", sa_req, 1);
    chk("postrst.port", sa_port, 1);
    step(8'h00, 1'b0, 3'd1, 1'b1);
    chk("postrst.out_head", out_flit, 8'h10);
    step(8'h00, 1'b0, 3'd1, 1'b0);
    chk("postrst.out_tail", out_flit, 8'h12);
    chk("postrst.fill_end", fill, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
